// File: rtl/oric_mem_pkg.sv
// Shared types and constants for the Oric-to-SDRAM bridge.
package oric_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [1:0] DS_WR_HI = 2'b10;
    localparam logic [1:0] DS_WR_LO = 2'b01;
    localparam logic [1:0] DS_RD    = 2'b11;

    localparam int TIMEOUT_DEFAULT = 255;

    // Byte enables for one access: a write touches only the addressed byte lane.
    function automatic logic [1:0] ds_encode(input logic we, input logic a0);
        logic [1:0] ds;
        if (we) begin
            ds = a0 ? DS_WR_HI : DS_WR_LO;
        end else begin
            ds = DS_RD;
        end
        return ds;
    endfunction

endpackage

// File: rtl/oric_strobe_sync.sv
// Two-flop synchroniser for the Oric cs/oe/we strobes into the clk_mem domain.
module oric_strobe_sync (
    input  logic       clk_mem,
    input  logic       reset,
    input  logic [2:0] async_i,
    output logic [2:0] sync_o
);
    logic [2:0] meta_d, meta_q;
    logic [2:0] sync_d, sync_q;

    // Next-state of the two synchroniser stages.
    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
    end

    // Stages reset low so a strobe held through reset is seen as a fresh edge.
    always_ff @(posedge clk_mem) begin
        if (reset) begin
            meta_q <= 3'b000;
            sync_q <= 3'b000;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/oric_mem_bridge.sv
// Bridges asynchronous Oric RAM strobes onto a toggle-handshake SDRAM port,
// with a one-deep pending slot, byte lane steering and an acknowledge timeout.
module oric_mem_bridge
    import oric_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk_mem,
    input  logic        reset,
    input  logic [15:0] ram_ad,
    input  logic [7:0]  ram_d,
    input  logic        ram_cs,
    input  logic        ram_oe,
    input  logic        ram_we,
    output logic [7:0]  ram_q,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [15:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic        port1_we,
    output logic [15:0] port1_d,
    input  logic [15:0] port1_q,
    output logic        busy,
    output logic        timeout_err
);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [2:0]  strb_s;
    logic        cs_s, rd_s, wr_s, trig_s, done_s, expire_s, issue_s;
    logic [15:0] iss_a_s;
    logic [7:0]  iss_d_s;
    logic        iss_we_s;

    state_e      state_d, state_q;
    logic [15:0] ad_d, ad_q, ad_prev_d, ad_prev_q;
    logic        rd_prev_d, rd_prev_q, wr_prev_d, wr_prev_q;
    logic        req_d, req_q;
    logic [15:0] a_d, a_q;
    logic [7:0]  d_d, d_q;
    logic        we_d, we_q;
    logic [1:0]  ds_d, ds_q;
    logic        pend_v_d, pend_v_q;
    logic [15:0] pend_a_d, pend_a_q;
    logic [7:0]  pend_d_d, pend_d_q;
    logic        pend_we_d, pend_we_q;
    logic [7:0]  cnt_d, cnt_q;
    logic [7:0]  rdata_d, rdata_q;
    logic        err_d, err_q;

    oric_strobe_sync u_sync (
        .clk_mem (clk_mem),
        .reset   (reset),
        .async_i ({ram_cs, ram_oe, ram_we}),
        .sync_o  (strb_s)
    );

    assign cs_s   = strb_s[2];
    assign rd_s   = strb_s[2] & strb_s[1];
    assign wr_s   = strb_s[2] & strb_s[0];
    // A new address under a held read is a new read (e.g. CPU stepping through memory).
    assign trig_s = (rd_s & ~rd_prev_q) | (wr_s & ~wr_prev_q) | (rd_s & (ad_q != ad_prev_q));

    // Next-state, handshake, pending slot and read capture.
    always_comb begin
        ad_d      = ram_ad;
        ad_prev_d = ad_q;
        rd_prev_d = rd_s;
        wr_prev_d = wr_s;
        state_d   = state_q;
        req_d     = req_q;
        a_d       = a_q;
        d_d       = d_q;
        we_d      = we_q;
        ds_d      = ds_q;
        pend_v_d  = pend_v_q;
        pend_a_d  = pend_a_q;
        pend_d_d  = pend_d_q;
        pend_we_d = pend_we_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        issue_s   = 1'b0;
        iss_a_s   = ad_q;
        iss_d_s   = ram_d;
        iss_we_s  = wr_s;
        done_s    = (req_q == port1_ack);
        expire_s  = (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                // Idle request phase follows ack so a stray ack never looks like a request.
                req_d   = port1_ack;
                issue_s = trig_s;
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (done_s || expire_s) begin
                    state_d = IDLE;
                    req_d   = port1_ack;
                    if (done_s) begin
                        if (!we_q) begin
                            rdata_d = a_q[0] ? port1_q[15:8] : port1_q[7:0];
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    if (trig_s) begin
                        issue_s  = 1'b1;
                        pend_v_d = 1'b0;
                    end else if (pend_v_q) begin
                        issue_s  = 1'b1;
                        iss_a_s  = pend_a_q;
                        iss_d_s  = pend_d_q;
                        iss_we_s = pend_we_q;
                        pend_v_d = 1'b0;
                    end else begin
                        pend_v_d = 1'b0;
                    end
                end else if (trig_s) begin
                    pend_v_d  = 1'b1;
                    pend_a_d  = ad_q;
                    pend_d_d  = ram_d;
                    pend_we_d = wr_s;
                end else begin
                    pend_v_d = pend_v_q;
                end
            end
            default: begin
                state_d  = IDLE;
                pend_v_d = 1'b0;
            end
        endcase

        if (issue_s) begin
            state_d = WAIT;
            req_d   = ~port1_ack;
            cnt_d   = 8'd0;
            a_d     = iss_a_s;
            d_d     = iss_d_s;
            we_d    = iss_we_s;
            ds_d    = ds_encode(iss_we_s, iss_a_s[0]);
        end else begin
            ds_d = ds_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_mem) begin
        if (reset) begin
            state_q   <= IDLE;
            ad_q      <= 16'h0000;
            ad_prev_q <= 16'h0000;
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
            req_q     <= port1_ack;
            a_q       <= 16'h0000;
            d_q       <= 8'h00;
            we_q      <= 1'b0;
            ds_q      <= 2'b00;
            pend_v_q  <= 1'b0;
            pend_a_q  <= 16'h0000;
            pend_d_q  <= 8'h00;
            pend_we_q <= 1'b0;
            cnt_q     <= 8'd0;
            rdata_q   <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ad_q      <= ad_d;
            ad_prev_q <= ad_prev_d;
            rd_prev_q <= rd_prev_d;
            wr_prev_q <= wr_prev_d;
            req_q     <= req_d;
            a_q       <= a_d;
            d_q       <= d_d;
            we_q      <= we_d;
            ds_q      <= ds_d;
            pend_v_q  <= pend_v_d;
            pend_a_q  <= pend_a_d;
            pend_d_q  <= pend_d_d;
            pend_we_q <= pend_we_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign ram_q       = cs_s ? rdata_q : 8'h00;
    assign port1_req   = req_q;
    assign port1_a     = a_q;
    assign port1_ds    = ds_q;
    assign port1_we    = we_q;
    assign port1_d     = {d_q, d_q};
    assign busy        = (state_q == WAIT) | pend_v_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_oric_mem_bridge.sv
// Randomised and directed bench for oric_mem_bridge against a transaction-level model.
module tb_oric_mem_bridge;

    logic        clk_mem = 1'b0;
    logic        reset;
    logic [15:0] ram_ad;
    logic [7:0]  ram_d;
    logic        ram_cs, ram_oe, ram_we;
    logic [7:0]  ram_q;
    logic        port1_req;
    logic        port1_ack = 1'b0;
    logic [15:0] port1_a;
    logic [1:0]  port1_ds;
    logic        port1_we;
    logic [15:0] port1_d;
    logic [15:0] port1_q = 16'h0000;
    logic        busy, timeout_err;

    int n_checks = 0;
    int n_errs   = 0;

    oric_mem_bridge #(.TIMEOUT(8)) dut (
        .clk_mem     (clk_mem),
        .reset       (reset),
        .ram_ad      (ram_ad),
        .ram_d       (ram_d),
        .ram_cs      (ram_cs),
        .ram_oe      (ram_oe),
        .ram_we      (ram_we),
        .ram_q       (ram_q),
        .port1_req   (port1_req),
        .port1_ack   (port1_ack),
        .port1_a     (port1_a),
        .port1_ds    (port1_ds),
        .port1_we    (port1_we),
        .port1_d     (port1_d),
        .port1_q     (port1_q),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk_mem = ~clk_mem;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SDRAM contents as the responder sees them.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h1235) return 16'hAB12;
        else if (a == 16'h2001) return 16'hC377;
        else return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [7:0] read_byte(input logic [15:0] a);
        logic [15:0] w;
        w = mem_word(a);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    // SDRAM responder: logs each request and toggles ack after resp_delay cycles.
    bit          resp_en    = 1'b1;
    int          resp_delay = 2;
    int          wait_left  = -1;
    logic [15:0] resp_word;
    logic [15:0] log_a[$];
    logic [1:0]  log_ds[$];
    logic        log_we[$];
    logic [15:0] log_d[$];

    always @(negedge clk_mem) begin
        if (wait_left > 0) begin
            wait_left--;
            if (wait_left == 0) begin
                port1_q   = resp_word;
                port1_ack = ~port1_ack;
                wait_left = -1;
            end
        end else if (resp_en && !reset && (port1_req != port1_ack)) begin
            log_a.push_back(port1_a);
            log_ds.push_back(port1_ds);
            log_we.push_back(port1_we);
            log_d.push_back(port1_d);
            resp_word = mem_word(port1_a);
            wait_left = resp_delay;
        end
    end

    logic [7:0] exp_hold = 8'h00;

    task automatic do_access(input bit is_wr, input logic [15:0] a, input logic [7:0] d, input int dly);
        int n0, nb;
        logic [1:0] exp_ds;
        n0 = log_a.size();
        resp_delay = dly;
        ram_ad = a;
        ram_d  = d;
        @(negedge clk_mem);
        ram_cs = 1'b1;
        ram_we = is_wr;
        ram_oe = ~is_wr;
        nb = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_mem);
            if (busy) nb++;
        end
        check_eq("req_count", 32'(log_a.size() - n0), 32'd1);
        if (log_a.size() > n0) begin
            exp_ds = is_wr ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
            check_eq("req_addr", 32'(log_a[n0]), 32'(a));
            check_eq("req_ds", 32'(log_ds[n0]), 32'(exp_ds));
            check_eq("req_we", 32'(log_we[n0]), 32'(is_wr));
            if (is_wr) check_eq("req_wdata", 32'(log_d[n0]), 32'({d, d}));
        end
        check_eq("busy_cycles", 32'(nb), 32'(dly + 1));
        if (!is_wr) exp_hold = read_byte(a);
        check_eq("ram_q", 32'(ram_q), 32'(exp_hold));
        ram_cs = 1'b0;
        ram_oe = 1'b0;
        ram_we = 1'b0;
        repeat (4) @(negedge clk_mem);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, nb, n0;
        reset  = 1'b1;
        ram_ad = 16'h0000;
        ram_d  = 8'h00;
        ram_cs = 1'b0;
        ram_oe = 1'b0;
        ram_we = 1'b0;
        repeat (3) @(negedge clk_mem);
        check_eq("rst_ram_q", 32'(ram_q), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_err", 32'(timeout_err), 32'h0);
        check_eq("rst_a", 32'(port1_a), 32'h0);
        check_eq("rst_ds", 32'(port1_ds), 32'h0);
        check_eq("rst_d", 32'(port1_d), 32'h0);
        check_eq("rst_req_eq_ack", 32'(port1_req == port1_ack), 32'h1);
        reset = 1'b0;
        repeat (3) @(negedge clk_mem);

        do_access(1'b0, 16'h1235, 8'h00, 4);
        check_eq("rd_1235", 32'(ram_q), 32'h0);
        do_access(1'b1, 16'h0400, 8'h5A, 3);
        do_access(1'b1, 16'h0401, 8'h3C, 2);

        // Two address changes while the first read is outstanding.
        resp_delay = 6;
        n0 = log_a.size();
        ram_ad = 16'h000F;
        @(negedge clk_mem);
        ram_cs = 1'b1;
        ram_oe = 1'b1;
        t = 0;
        while (port1_req == port1_ack && t < 20) begin
            @(negedge clk_mem);
            t++;
        end
        nb = busy ? 1 : 0;
        ram_ad = 16'h0010;
        repeat (2) begin
            @(negedge clk_mem);
            if (busy) nb++;
        end
        ram_ad = 16'h0011;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_mem);
            if (busy) nb++;
        end
        check_eq("pend_req_count", 32'(log_a.size() - n0), 32'd2);
        if (log_a.size() >= n0 + 2) check_eq("pend_addr", 32'(log_a[n0 + 1]), 32'h0011);
        check_eq("pend_busy_cycles", 32'(nb), 32'd14);
        exp_hold = read_byte(16'h0011);
        check_eq("pend_ram_q", 32'(ram_q), 32'(exp_hold));
        ram_cs = 1'b0;
        ram_oe = 1'b0;
        repeat (4) @(negedge clk_mem);

        // Withheld ack: timeout after eight cycles.
        resp_en = 1'b0;
        ram_ad  = 16'h0300;
        @(negedge clk_mem);
        ram_cs = 1'b1;
        ram_oe = 1'b1;
        t = 0;
        while (port1_req == port1_ack && t < 20) begin
            @(negedge clk_mem);
            t++;
        end
        check_eq("to_issued", 32'(port1_req != port1_ack), 32'h1);
        repeat (7) @(negedge clk_mem);
        check_eq("to_err_early", 32'(timeout_err), 32'h0);
        check_eq("to_busy_early", 32'(busy), 32'h1);
        @(negedge clk_mem);
        check_eq("to_err", 32'(timeout_err), 32'h1);
        check_eq("to_busy", 32'(busy), 32'h0);
        check_eq("to_resync", 32'(port1_req == port1_ack), 32'h1);
        check_eq("to_ram_q", 32'(ram_q), 32'(exp_hold));
        ram_cs = 1'b0;
        ram_oe = 1'b0;
        repeat (4) @(negedge clk_mem);
        resp_en = 1'b1;
        do_access(1'b0, 16'h0301, 8'h00, 3);
        check_eq("to_sticky", 32'(timeout_err), 32'h1);

        // Reset in the middle of an access, ack arriving afterwards.
        resp_delay = 6;
        ram_ad = 16'h0500;
        @(negedge clk_mem);
        ram_cs = 1'b1;
        ram_oe = 1'b1;
        t = 0;
        while (port1_req == port1_ack && t < 20) begin
            @(negedge clk_mem);
            t++;
        end
        repeat (2) @(negedge clk_mem);
        reset  = 1'b1;
        ram_cs = 1'b0;
        ram_oe = 1'b0;
        repeat (2) @(negedge clk_mem);
        reset = 1'b0;
        exp_hold = 8'h00;
        n0 = log_a.size();
        repeat (12) @(negedge clk_mem);
        check_eq("rstw_no_req", 32'(log_a.size() - n0), 32'd0);
        check_eq("rstw_req_eq_ack", 32'(port1_req == port1_ack), 32'h1);
        check_eq("rstw_busy", 32'(busy), 32'h0);
        check_eq("rstw_err", 32'(timeout_err), 32'h0);
        check_eq("rstw_a", 32'(port1_a), 32'h0);
        check_eq("rstw_we", 32'(port1_we), 32'h0);
        check_eq("rstw_ds", 32'(port1_ds), 32'h0);
        check_eq("rstw_ram_q", 32'(ram_q), 32'h0);

        for (int k = 0; k < 24; k++) begin
            do_access(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), $urandom_range(1, 6));
        end

        // Output gating by chip select.
        do_access(1'b0, 16'h2001, 8'h00, 2);
        check_eq("cs_low_q", 32'(ram_q), 32'h0);
        ram_cs = 1'b1;
        repeat (3) @(negedge clk_mem);
        check_eq("cs_high_q", 32'(ram_q), 32'hC3);
        ram_cs = 1'b0;
        repeat (3) @(negedge clk_mem);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/oric_mem_bridge.md
ORIC_MEM_BRIDGE -- requirements
Module: oric_mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, maximum clk_mem cycles to wait for an SDRAM acknowledge.
REQ-002 SHALL have port clk_mem  input  1  single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ram_ad  input  16  Oric byte address.
REQ-005 SHALL have port ram_d  input  8  Oric write data.
REQ-006 SHALL have port ram_cs / ram_oe / ram_we  input  1 each  Oric chip select, output enable and write strobe (asynchronous to clk_mem, already stable over a phi2 phase).
REQ-007 SHALL have port ram_q  output  8  read byte to Oric.
REQ-008 SHALL have port port1_req  output  1  toggle-style request to sdram port 1.
REQ-009 SHALL have port port1_ack  input  1  toggle-style acknowledge from sdram port 1.
REQ-010 SHALL have port port1_a  output  16  latched byte address.
REQ-011 SHALL have port port1_ds  output  2  byte enables.
REQ-012 SHALL have port port1_we  output  1  latched write flag.
REQ-013 SHALL have port port1_d  output  16  write data.
REQ-014 SHALL have port port1_q  input  16  read word from sdram.
REQ-015 SHALL have port busy  output  1  high while a request is outstanding.
REQ-016 SHALL have port timeout_err  output  1  sticky error flag.

Function
REQ-017 SHALL double-register ram_cs, ram_oe and ram_we, and register ram_ad, before use; "rd" = cs&oe and "wr" = cs&we refer to the synchronised values.
REQ-018 SHALL raise a trigger on a rising edge of rd, a rising edge of wr, or a change of registered ram_ad while rd is high.
REQ-019 In IDLE, a trigger SHALL latch address, data and we, toggle port1_req on the next edge, and move to WAIT.
REQ-020 In WAIT, port1_ack equal to port1_req SHALL complete the access, and the FSM SHALL return to IDLE on the same edge.
REQ-021 A trigger arriving in WAIT SHALL be stored in a one-deep pending slot, with address, data and we captured.
REQ-022 A newer trigger SHALL overwrite the pending slot; only the last one is kept.
REQ-023 On completion with the pending slot valid, the FSM SHALL issue the pending request on the next edge without passing through an idle cycle.
REQ-024 A trigger on the same edge as completion SHALL be issued directly, as if in IDLE.
REQ-025 port1_ds SHALL be 2'b10 for a write with a0=1, 2'b01 for a write with a0=0, and 2'b11 for a read.
REQ-026 port1_d SHALL be {d,d} from the latched write data.
REQ-027 On read completion, the bridge SHALL capture port1_q[15:8] if latched a0=1, else port1_q[7:0], into the read holding register.
REQ-028 A write completion SHALL leave the read holding register unchanged.
REQ-029 ram_q SHALL equal the read holding register while synchronised cs is high, else 8'h00.
REQ-030 busy SHALL be high in WAIT, or while the pending slot is valid.
REQ-031 An 8-bit wait counter SHALL clear on each issue and increment in WAIT.
REQ-032 When the wait counter reaches TIMEOUT, the bridge SHALL set timeout_err and drop the access (read register unchanged).
REQ-033 On timeout, the FSM SHALL resynchronise internal request phase to port1_ack and go to IDLE, or issue pending if the slot is valid.
REQ-034 timeout_err SHALL clear only on reset.
REQ-035 FSM states SHALL be exactly IDLE and WAIT; no other encodings are reachable.

Reset
REQ-036 On reset, FSM SHALL go to IDLE, the pending slot SHALL be invalid, and the wait counter SHALL clear.
REQ-037 On reset, ram_q SHALL be 8'h00, busy 0, timeout_err 0, and port1_a/port1_d/port1_we/port1_ds 0.
REQ-038 On reset, port1_req SHALL keep its level but be set equal to port1_ack, so that no spurious request is issued.
REQ-039 Reset mid-WAIT SHALL abandon the access; a late ack SHALL be ignored (req already equal).
REQ-040 Synchroniser flops SHALL reset to 0, so that a cs/oe held high through reset produces a trigger on release.

Structure
REQ-041 The state enum, the DS encodings and the default TIMEOUT SHALL live in shared package oric_mem_pkg.
REQ-042 The three-bit strobe synchroniser SHALL be sub-module oric_strobe_sync, instantiated once.

Verification
REQ-043 Read at 16'h1235 (port1_q=16'hAB12, ack 4 cycles after req) -> port1_ds=2'b11, ram_q=8'hAB, busy 1 for 5 cycles.
REQ-044 Write 8'h5A at 16'h0400 -> port1_ds=2'b01, port1_d=16'h5A5A, port1_we=1, ram_q unchanged.
REQ-045 Two address changes during one outstanding read (0x10 then 0x11) -> exactly two requests issued, with second port1_a=0x11; 0x10 dropped.
REQ-046 Ack withheld with TIMEOUT=8 -> timeout_err=1 at cycle 8, FSM IDLE, next read completes normally.
REQ-047 Reset asserted 2 cycles after req toggle, ack arrives after reset -> no further request, outputs at reset values.
REQ-048 cs low with holding register 8'hC3 -> ram_q=8'h00; cs high again -> 8'hC3.
